hub75e_frame_buffer: RTL and testbench
======================================

// Module: hub75e_frame_buffer
// PURPOSE
//   Double-buffered pixel store feeding hub75e_led_matrix. The driver's x/y scan
//   coordinates read the front buffer combinationally into red/green/blue. A user
//   writer fills the back buffer through a valid/ready port. A swap request flips
//   front and back buffers, but only at the next frame boundary, so no frame tears.
// PARAMETERS
//   screen_width   64                     pixels per row
//   screen_height  64                     rows per frame
//   w_red          1                      red bits per pixel
//   w_green        1                      green bits per pixel
//   w_blue         1                      blue bits per pixel
//   w_x            $clog2(screen_width)   column coordinate width
//   w_y            $clog2(screen_height)  row coordinate width
// PORTS
//   clk        in   1        clock
//   rst        in   1        reset, asynchronous, active-high
//   x          in   w_x      scan column from the matrix driver
//   y          in   w_y      scan row from the matrix driver
//   red        out  w_red    front-buffer pixel at (x,y); combinational
//   green      out  w_green  front-buffer pixel at (x,y); combinational
//   blue       out  w_blue   front-buffer pixel at (x,y); combinational
//   wr_valid   in   1        write request
//   wr_ready   out  1        write accepted when wr_valid & wr_ready
//   wr_x       in   w_x      write column
//   wr_y       in   w_y      write row
//   wr_rgb     in   w_red+w_green+w_blue  pixel as {r,g,b}
//   swap_valid in   1        request a buffer flip
//   swap_ready out  1        high when no flip is pending
//   swap_done  out  1        one-cycle pulse in the cycle after the flip
//   front_sel  out  1        index of the buffer currently displayed
// BEHAVIOUR
//   - Reset values: front_sel=0, swap pending=0, swap_done=0, swap_ready=1,
//     wr_ready=1. The frame-boundary detector's previous-y register resets to 0.
//     Pixel memory is not reset.
//   - Read path: {red,green,blue} = mem[front_sel][y][x]. There is no register on this
//     path, so latency is 0; the driver samples the pixel in the same cycle it presents x/y.
//   - Write: on wr_valid & wr_ready, mem[~front_sel][wr_y][wr_x] <= wr_rgb at that
//     clock edge. A write with wr_x >= screen_width or wr_y >= screen_height is
//     accepted and dropped.
//   - Swap handshake: swap_valid & swap_ready sets pending; swap_ready = ~pending.
//   - wr_ready = ~pending (and ~clearing when the optional feature is enabled).
//     Writes therefore stall from swap acceptance until the flip.
//   - Frame boundary: y_prev registers y every clock. A boundary is
//     (y == 0) && (y_prev == screen_height-1).
//   - Flip: in the cycle where a boundary occurs and pending=1, toggle front_sel
//     and clear pending; swap_done=1 in the following cycle only.
//   - Simultaneous write and swap acceptance: the write lands in the old back buffer.
//     Pending is set next cycle. wr_ready is computed from pre-edge state.
//   - Swap accepted in the same cycle as a boundary: it is not applied until the
//     next boundary, because pending was 0 when that boundary was sampled.
//   - A boundary with pending=0 changes nothing.
//   - Reset mid-operation: the flip and any pending swap are abandoned; front_sel
//     returns to 0. Memory keeps its contents.
// CONFIGURATION
//   HUB75_FB_CLEAR_EN
//   - Defined: a clear engine writes 0 to the new back buffer after every flip.
//     - It starts the cycle after the flip and covers one pixel per clock,
//       row-major, screen_width*screen_height cycles.
//     - During clearing, wr_ready=0 and swap_ready=0.
//     - After reset, the engine clears the same address in both buffers each cycle.
//   - Undefined: no clear engine. The back buffer keeps stale contents, and
//     wr_ready/swap_ready depend on pending only.
// TESTING
//   - Write (3,5)=3'b101 with front_sel=0, no swap: reads at (3,5) return
//     the old front-buffer value; wr_ready stays 1.
//   - Write (3,5)=3'b101, pulse swap_valid mid-frame: swap_ready=0 and wr_ready=0
//     until y goes 63->0. Then front_sel=1, swap_done pulses for one cycle, and
//     reading (3,5) returns 3'b101.
//   - Assert swap_valid in the exact cycle of a y 63->0 boundary: no flip on that
//     boundary; the flip happens on the next boundary.
//   - Write to (64,0) with screen_width=64: the handshake completes, and no pixel in
//     either buffer changes.
//   - Assert rst while a swap is pending: front_sel=0, swap_ready=1, swap_done=0.
//     After release, no flip occurs at the next boundary.
//   - With HUB75_FB_CLEAR_EN defined: after a flip, wr_ready=0 for exactly 4096
//     cycles. Every pixel of the new back buffer then reads 0 after a second flip.

Source files
------------

// File: rtl/hub75e_frame_buffer.sv
// Double-buffered pixel store for hub75e_led_matrix. Front/back flip only at a y wrap.
// Optional HUB75_FB_CLEAR_EN: zero the new back buffer after each flip (and both after reset).
module hub75e_frame_buffer #(
    parameter int screen_width  = 64,
    parameter int screen_height = 64,
    parameter int w_red         = 1,
    parameter int w_green       = 1,
    parameter int w_blue        = 1,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [w_x-1:0]                 x,
    input  logic [w_y-1:0]                 y,
    output logic [w_red-1:0]               red,
    output logic [w_green-1:0]             green,
    output logic [w_blue-1:0]              blue,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [w_x-1:0]                 wr_x,
    input  logic [w_y-1:0]                 wr_y,
    input  logic [w_red+w_green+w_blue-1:0] wr_rgb,
    input  logic                           swap_valid,
    output logic                           swap_ready,
    output logic                           swap_done,
    output logic                           front_sel
);
    localparam int W_RGB = w_red + w_green + w_blue;
    localparam int NPIX  = screen_width * screen_height;
    localparam int AW    = $clog2(2 * NPIX);
    localparam int PW    = $clog2(NPIX);

    logic [W_RGB-1:0] mem [2*NPIX];

    logic           front_sel_q, front_sel_d;
    logic           pending_q, pending_d;
    logic           swap_done_q, swap_done_d;
    logic [w_y-1:0] y_prev_q, y_prev_d;
    logic           boundary, flip, busy;
    logic           swap_fire, wr_fire, wr_ok, rd_ok;
    logic [AW-1:0]  rd_idx, wr_idx;
    logic [W_RGB-1:0] rd_pix;

    function automatic logic [AW-1:0] lin_addr(input logic [w_y-1:0] yy,
                                               input logic [w_x-1:0] xx);
        return AW'(yy) * AW'(screen_width) + AW'(xx);
    endfunction

    function automatic logic [AW-1:0] pix_addr(input logic sel,
                                               input logic [AW-1:0] lin);
        return sel ? AW'(NPIX) + lin : lin;
    endfunction

`ifdef HUB75_FB_CLEAR_EN
    logic          clearing_q, clearing_d;
    logic          clr_both_q, clr_both_d;
    logic [PW-1:0] clr_addr_q, clr_addr_d;
    assign busy = pending_q | clearing_q;
`else
    assign busy = pending_q;
`endif

    assign wr_ready   = ~busy;
    assign swap_ready = ~busy;
    assign swap_done  = swap_done_q;
    assign front_sel  = front_sel_q;

    always_comb begin
        swap_fire = swap_valid & swap_ready;
        wr_fire   = wr_valid & wr_ready;
        wr_ok     = (int'(wr_x) < screen_width) && (int'(wr_y) < screen_height);
        rd_ok     = (int'(x) < screen_width) && (int'(y) < screen_height);
        wr_idx    = pix_addr(~front_sel_q, lin_addr(wr_y, wr_x));
        rd_idx    = pix_addr(front_sel_q, lin_addr(y, x));
        rd_pix    = rd_ok ? mem[rd_idx] : '0;
        boundary  = (y == '0) && (y_prev_q == w_y'(screen_height - 1));
        flip      = boundary & pending_q;
        front_sel_d = front_sel_q ^ flip;
        swap_done_d = flip;
        y_prev_d    = y;
        pending_d   = pending_q;
        if (flip)
            pending_d = 1'b0;
        else if (swap_fire)
            pending_d = 1'b1;
`ifdef HUB75_FB_CLEAR_EN
        clearing_d = clearing_q;
        clr_both_d = clr_both_q;
        clr_addr_d = clr_addr_q;
        if (flip) begin
            clearing_d = 1'b1;
            clr_both_d = 1'b0;
            clr_addr_d = '0;
        end else if (clearing_q) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == PW'(NPIX - 1)) begin
                clearing_d = 1'b0;
                clr_both_d = 1'b0;
            end
        end
`endif
    end

    assign red   = rd_pix[W_RGB-1 -: w_red];
    assign green = rd_pix[w_green+w_blue-1 -: w_green];
    assign blue  = rd_pix[w_blue-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            y_prev_q    <= '0;
        end else begin
            front_sel_q <= front_sel_d;
            pending_q   <= pending_d;
            swap_done_q <= swap_done_d;
            y_prev_q    <= y_prev_d;
        end
    end

`ifdef HUB75_FB_CLEAR_EN
    // After reset neither buffer is trusted, so both are wiped in lockstep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clearing_q <= 1'b1;
            clr_both_q <= 1'b1;
            clr_addr_q <= '0;
        end else begin
            clearing_q <= clearing_d;
            clr_both_q <= clr_both_d;
            clr_addr_q <= clr_addr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_fire && wr_ok)
            mem[wr_idx] <= wr_rgb;
`ifdef HUB75_FB_CLEAR_EN
        if (clearing_q) begin
            mem[pix_addr(~front_sel_q, AW'(clr_addr_q))] <= '0;
            if (clr_both_q)
                mem[pix_addr(front_sel_q, AW'(clr_addr_q))] <= '0;
        end
`endif
    end
endmodule

// File: tb/tb_hub75e_frame_buffer.sv
// Directed bench for hub75e_frame_buffer: vector table plus swap/reset corner sequences.
module tb_hub75e_frame_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] x = 7'd0, y = 7'd5;
    logic       red, green, blue;
    logic       wr_valid = 1'b0, wr_ready;
    logic [6:0] wr_x = 7'd0, wr_y = 7'd0;
    logic [2:0] wr_rgb = 3'd0;
    logic       swap_valid = 1'b0, swap_ready, swap_done, front_sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hub75e_frame_buffer #(.w_x(7), .w_y(7)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .red(red), .green(green), .blue(blue),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .swap_valid(swap_valid), .swap_ready(swap_ready),
        .swap_done(swap_done), .front_sel(front_sel)
    );

    typedef struct {
        logic [6:0] x, y;
        logic       wv;
        logic [6:0] wx, wy;
        logic [2:0] wrgb;
        logic       sv;
        logic [2:0] e_rgb;
        logic       e_wr, e_sw, e_fs, e_done;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int wx, input int wy, input int rgb);
        wr_valid = 1'b1;
        wr_x = 7'(wx);
        wr_y = 7'(wy);
        wr_rgb = 3'(rgb);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic boundary();
        y = 7'd63;
        step();
        y = 7'd0;
        step();
    endtask

    task automatic rd(input string name, input int rx, input int ry, input int exp);
        x = 7'(rx);
        y = 7'(ry);
        #1;
        chk(name, {red, green, blue}, exp);
    endtask

    initial begin
        tbl[0] = '{7'd3, 7'd5, 1'b1, 7'd3, 7'd5, 3'b101, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{7'd0, 7'd0, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{7'd63, 7'd63, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{7'd3, 7'd5, 1'b1, 7'd10, 7'd5, 3'b111, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{7'd3, 7'd5, 1'b1, 7'd10, 7'd6, 3'b011, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{7'd63, 7'd63, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{7'd0, 7'd0, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{7'd3, 7'd5, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{7'd10, 7'd5, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{7'd10, 7'd6, 1'b0, 7'd0, 7'd0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};

        step();
        step();
        chk("rst_front_sel", front_sel, 0);
        chk("rst_swap_ready", swap_ready, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_swap_done", swap_done, 0);
        rst = 1'b0;
        step();

        wr(3, 5, 3'b010);
        wr(0, 0, 3'b011);
        wr(63, 63, 3'b110);
        wr(10, 6, 3'b000);
        wr(0, 1, 3'b101);
        swap_valid = 1'b1;
        step();
        swap_valid = 1'b0;
        boundary();
        chk("init_flip1", front_sel, 1);
        y = 7'd5;
        step();
        rd("init_rd_buf1", 3, 5, 3'b010);
        wr(3, 5, 3'b001);
        wr(0, 0, 3'b100);
        wr(63, 63, 3'b111);
        wr(0, 1, 3'b010);
        swap_valid = 1'b1;
        step();
        swap_valid = 1'b0;
        boundary();
        chk("init_flip0", front_sel, 0);
        y = 7'd5;
        step();

        for (int i = 0; i < 10; i++) begin
            x = tbl[i].x;
            y = tbl[i].y;
            wr_valid = tbl[i].wv;
            wr_x = tbl[i].wx;
            wr_y = tbl[i].wy;
            wr_rgb = tbl[i].wrgb;
            swap_valid = tbl[i].sv;
            step();
            chk($sformatf("v%0d_rgb", i), {red, green, blue}, tbl[i].e_rgb);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, tbl[i].e_wr);
            chk($sformatf("v%0d_swap_ready", i), swap_ready, tbl[i].e_sw);
            chk($sformatf("v%0d_front_sel", i), front_sel, tbl[i].e_fs);
            chk($sformatf("v%0d_swap_done", i), swap_done, tbl[i].e_done);
        end
        wr_valid = 1'b0;
        swap_valid = 1'b0;

        y = 7'd63;
        step();
        y = 7'd0;
        swap_valid = 1'b1;
        step();
        swap_valid = 1'b0;
        chk("bnd_swap_no_flip", front_sel, 1);
        chk("bnd_swap_pending", swap_ready, 0);
        chk("bnd_swap_done0", swap_done, 0);
        y = 7'd5;
        step();
        chk("bnd_swap_still1", front_sel, 1);
        boundary();
        chk("bnd_next_flip", front_sel, 0);
        chk("bnd_next_done", swap_done, 1);
        y = 7'd5;
        step();
        chk("bnd_done_pulse", swap_done, 0);
        chk("bnd_ready_back", swap_ready, 1);
        rd("bnd_rd_front0", 3, 5, 3'b001);

        y = 7'd5;
        wr_valid = 1'b1;
        wr_x = 7'd64;
        wr_y = 7'd0;
        wr_rgb = 3'b111;
        #1;
        chk("oor_wr_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        rd("oor_buf0_00", 0, 0, 3'b100);
        rd("oor_buf0_01", 0, 1, 3'b010);
        y = 7'd5;
        swap_valid = 1'b1;
        step();
        swap_valid = 1'b0;
        boundary();
        chk("oor_flip", front_sel, 1);
        rd("oor_buf1_00", 0, 0, 3'b011);
        rd("oor_buf1_01", 0, 1, 3'b101);

        y = 7'd5;
        step();
        swap_valid = 1'b1;
        step();
        swap_valid = 1'b0;
        chk("rstp_pending", swap_ready, 0);
        rst = 1'b1;
        #1;
        chk("rstp_front_sel", front_sel, 0);
        chk("rstp_swap_ready", swap_ready, 1);
        chk("rstp_swap_done", swap_done, 0);
        chk("rstp_wr_ready", wr_ready, 1);
        step();
        rst = 1'b0;
        step();
        boundary();
        chk("rstp_no_flip", front_sel, 0);
        chk("rstp_no_done", swap_done, 0);
        rd("rstp_mem_kept", 3, 5, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
